// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and default widths for mem_port_arbiter
// Contents: FSM state enum, owner encoding, default ADDR_W/DATA_W/MEM_LAT.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MEM_LAT = 1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory port bundle for mem_port_arbiter
// Fetch:  if_req, if_addr -> if_ack, if_rdata
// Data:   dm_req, dm_we, dm_addr, dm_wdata -> dm_ack, dm_rdata
// Memory: mem_addr, mem_we, mem_din -> mem_dout
// Status: busy
// slave = arbiter view, master = requester/memory view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_we, mem_din, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_we, mem_din, busy
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick2.sv
// rtl/mem_port_arbiter_arb_pick2.sv - combinational two-requester owner picker
// Inputs: if_req, dm_req, last_grant. Output: owner.
// ARB_RR_EN defined: tie goes to the requester not granted last; otherwise dm always wins.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
    input  owner_e last_grant,
    output owner_e owner
);

`ifdef ARB_RR_EN
    always_comb begin
        owner = OWN_IF;
        if (if_req && dm_req) begin
            owner = (last_grant == OWN_DM) ? OWN_IF : OWN_DM;
        end else if (dm_req) begin
            owner = OWN_DM;
        end
    end
`else
    // Fixed priority needs neither if_req nor the pointer.
    logic [1:0] unused_pick;
    assign unused_pick = {if_req, last_grant};

    always_comb begin
        owner = dm_req ? OWN_DM : OWN_IF;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data requesters
// Ports: clk, reset (sync, active-high), bus (mem_port_arbiter_if.slave).
// Sequence per transaction: IDLE grant -> MEM_LAT ACCESS cycles -> one RESP cycle with ack.
// Optional ARB_RR_EN: round-robin tie breaking with a last-grant pointer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int                CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              mem_we_q, mem_we_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    owner_e            pick;
    owner_e            last_grant;

`ifdef ARB_RR_EN
    owner_e            last_q, last_d;
    assign last_grant = last_q;
`else
    assign last_grant = OWN_IF;
`endif

    arb_pick2 u_pick (
        .if_req     (bus.if_req),
        .dm_req     (bus.dm_req),
        .last_grant (last_grant),
        .owner      (pick)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = 1'b0;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
`ifdef ARB_RR_EN
        last_d     = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = ACCESS;
                    if (pick == OWN_DM) begin
                        mem_addr_d = bus.dm_addr;
                        mem_din_d  = bus.dm_wdata;
                        we_d       = bus.dm_we;
                        // Strobe is registered here so it is high in the first ACCESS cycle only.
                        mem_we_d   = bus.dm_we;
                    end else begin
                        mem_addr_d = bus.if_addr;
                        we_d       = 1'b0;
                    end
`ifdef ARB_RR_EN
                    last_d = pick;
`endif
                end
            end

            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    // Ack and data are registered on this edge so they appear during RESP.
                    if (owner_q == OWN_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_dout;
                    end else begin
                        dm_ack_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = bus.mem_dout;
                        end
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef ARB_RR_EN
            last_q     <= OWN_IF;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.if_ack   = if_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_ack   = dm_ack_q;
    assign bus.dm_rdata = dm_rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        owner_e      own;
        logic [31:0] ird;
        logic [31:0] drd;
    } ack_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    ack_exp_t    aq[$];
    wr_exp_t     wq[$];
    logic [31:0] ref_mem [256];
    logic [31:0] mem_wr [256];
    logic        mem_wv [256] = '{default: 1'b0};
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;
    owner_e      model_last;
    int          n_chk = 0;
    int          n_fail = 0;
    int          busy_run = 0;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 16) return 32'h2002_000A;
        return 32'h5A00_0000 ^ (idx * 32'h0001_0203);
    endfunction

    // Memory with data visible as soon as the address is driven.
    assign bus.mem_dout = mem_wv[bus.mem_addr[9:2]] ? mem_wr[bus.mem_addr[9:2]]
                                                    : init_word(int'(bus.mem_addr[9:2]));
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem_wr[bus.mem_addr[9:2]] <= bus.mem_din;
            mem_wv[bus.mem_addr[9:2]] <= 1'b1;
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout expected ack", name);
    endfunction

    // Reference: grants execute in order against a flat memory array.
    function automatic void apply_model(input owner_e own, input logic [31:0] ia, input logic [31:0] da,
                                        input logic dwe, input logic [31:0] dwd);
        ack_exp_t e;
        if (own == OWN_IF) begin
            exp_ird = ref_mem[ia[9:2]];
        end else if (dwe) begin
            ref_mem[da[9:2]] = dwd;
            wq.push_back('{addr: da, data: dwd});
        end else begin
            exp_drd = ref_mem[da[9:2]];
        end
        e.own = own;
        e.ird = exp_ird;
        e.drd = exp_drd;
        aq.push_back(e);
        model_last = own;
    endfunction

    function automatic owner_e tie_winner();
`ifdef ARB_RR_EN
        return (model_last == OWN_DM) ? OWN_IF : OWN_DM;
`else
        return OWN_DM;
`endif
    endfunction

    function automatic void model_reset();
        exp_ird    = '0;
        exp_drd    = '0;
        model_last = OWN_IF;
    endfunction

    // Monitor: every strobe and ack is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            busy_run = bus.busy ? busy_run + 1 : 0;
            if (bus.mem_we === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("unexpected_mem_we", 1, 0);
                end else begin
                    wr_exp_t w;
                    w = wq.pop_front();
                    chk("mem_addr", bus.mem_addr, w.addr);
                    chk("mem_din", bus.mem_din, w.data);
                end
            end
            if (bus.if_ack === 1'b1 && bus.dm_ack === 1'b1) chk("both_acks", 1, 0);
            if (bus.if_ack === 1'b1 || bus.dm_ack === 1'b1) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    ack_exp_t e;
                    e = aq.pop_front();
                    chk("ack_owner", (bus.dm_ack === 1'b1) ? 1 : 0, e.own);
                    chk("if_rdata", bus.if_rdata, e.ird);
                    chk("dm_rdata", bus.dm_rdata, e.drd);
                    chk("busy_cycles_at_ack", busy_run, LAT + 1);
                end
            end
        end else begin
            busy_run = 0;
        end
    end

    task automatic run_round(input bit do_if, input bit do_dm, input logic [31:0] ia, input logic [31:0] da,
                             input logic dwe, input logic [31:0] dwd, input bit drop_early);
        int     cyc;
        int     acks;
        bit     pend_if;
        bit     pend_dm;
        owner_e first;
        owner_e granted;
        first = OWN_DM;
        if (do_if && do_dm) begin
            first = tie_winner();
            if (first == OWN_DM) begin
                apply_model(OWN_DM, ia, da, dwe, dwd);
                apply_model(OWN_IF, ia, da, dwe, dwd);
            end else begin
                apply_model(OWN_IF, ia, da, dwe, dwd);
                apply_model(OWN_DM, ia, da, dwe, dwd);
            end
            granted = first;
        end else if (do_dm) begin
            apply_model(OWN_DM, ia, da, dwe, dwd);
            granted = OWN_DM;
        end else begin
            apply_model(OWN_IF, ia, da, dwe, dwd);
            granted = OWN_IF;
        end
        @(negedge clk);
        bus.if_addr  = ia;
        bus.dm_addr  = da;
        bus.dm_we    = dwe;
        bus.dm_wdata = dwd;
        bus.if_req   = do_if;
        bus.dm_req   = do_dm;
        pend_if = do_if;
        pend_dm = do_dm;
        cyc  = 0;
        acks = 0;
        while ((pend_if || pend_dm) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.if_ack === 1'b1 && pend_if) begin
                pend_if    = 1'b0;
                bus.if_req = 1'b0;
                chk("if_ack_cycle", cyc, LAT + 1 + acks * (LAT + 2));
                acks++;
            end
            if (bus.dm_ack === 1'b1 && pend_dm) begin
                pend_dm    = 1'b0;
                bus.dm_req = 1'b0;
                chk("dm_ack_cycle", cyc, LAT + 1 + acks * (LAT + 2));
                acks++;
            end
            // Granted requester's inputs change after the grant edge; they must not matter.
            if (cyc == 1) begin
                if (granted == OWN_DM) begin
                    bus.dm_addr  = $urandom;
                    bus.dm_wdata = $urandom;
                    bus.dm_we    = ~dwe;
                    if (drop_early && !do_if) bus.dm_req = 1'b0;
                end else begin
                    bus.if_addr = $urandom;
                    if (drop_early && !do_dm) bus.if_req = 1'b0;
                end
            end
        end
        if (pend_if || pend_dm) fail_now("round_timeout");
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    task automatic hold_both(input int n, input logic [31:0] ia, input logic [31:0] da);
        int acks;
        int cyc;
        for (int k = 0; k < n; k++) apply_model(tie_winner(), ia, da, 1'b0, 32'h0);
        @(negedge clk);
        bus.if_addr = ia;
        bus.dm_addr = da;
        bus.dm_we   = 1'b0;
        bus.if_req  = 1'b1;
        bus.dm_req  = 1'b1;
        acks = 0;
        cyc  = 0;
        while (acks < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.if_ack === 1'b1 || bus.dm_ack === 1'b1) begin
                chk("hold_ack_cycle", cyc, LAT + 1 + acks * (LAT + 2));
                acks++;
                if (acks == n) begin
                    bus.if_req = 1'b0;
                    bus.dm_req = 1'b0;
                end
            end
        end
        if (acks < n) fail_now("hold_timeout");
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    task automatic reset_mid_write(input logic [31:0] da, input logic [31:0] dwd);
        apply_model(OWN_DM, 32'h0, da, 1'b1, dwd);
        void'(aq.pop_back());
        @(negedge clk);
        bus.dm_addr  = da;
        bus.dm_wdata = dwd;
        bus.dm_we    = 1'b1;
        bus.dm_req   = 1'b1;
        @(negedge clk);
        chk("midrst_busy_before", bus.busy, 1);
        #1;
        reset      = 1'b1;
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk("midrst_mem_we", bus.mem_we, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_dm_ack", bus.dm_ack, 0);
        chk("midrst_dm_rdata", bus.dm_rdata, 0);
        chk("midrst_if_rdata", bus.if_rdata, 0);
        model_reset();
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_idle_busy", bus.busy, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();
        reset        = 1'b1;
        bus.if_req   = 1'b1;
        bus.dm_req   = 1'b1;
        bus.if_addr  = 32'h40;
        bus.dm_addr  = 32'h100;
        bus.dm_we    = 1'b1;
        bus.dm_wdata = 32'hFFFF_FFFF;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_if_ack", bus.if_ack, 0);
        chk("rst_dm_ack", bus.dm_ack, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_din", bus.mem_din, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_busy", bus.busy, 0);
        reset      = 1'b0;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_busy", bus.busy, 0);
        end

        run_round(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);
        run_round(1'b0, 1'b1, 32'h0, 32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0);
        run_round(1'b0, 1'b1, 32'h0, 32'h100, 1'b0, 32'h0, 1'b0);
        hold_both(4, 32'h44, 32'h100);
        reset_mid_write(32'h80, 32'h1234_5678);
        run_round(1'b1, 1'b1, 32'h100, 32'h100, 1'b1, 32'hCAFE_F00D, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_round(mode != 1, mode != 0,
                      32'($urandom_range(0, 31)) << 2, 32'($urandom_range(0, 31)) << 2,
                      1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("ack_queue_empty", aq.size(), 0);
        chk("wr_queue_empty", wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory between the instruction-fetch requester and the data-access requester of the MIPS-subset core. It is the step toward a unified instruction/data memory. The block arbitrates the two requesters and sequences each transaction: arbitrate, memory access of fixed latency, then response. Each requester gets a one-cycle acknowledge pulse with registered read data. The core stalls on its requester until that ack arrives.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory cycles from address driven to valid mem_dout; legal range ≥1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DATA_W  fetch data, valid while if_ack=1
- dm_req  in  1  data request, level
- dm_we  in  1  1=write, 0=read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_ack  out  1  one-cycle data completion pulse
- dm_rdata  out  DATA_W  read data, valid while dm_ack=1 (reads only)
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data
- busy  out  1  high when state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample if_req and dm_req. If either is set, choose an owner (priority rules below).
  - Latch the owner's address. For the data requester, also latch we and wdata; a fetch latches we=0.
  - Clear the latency counter and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_addr, mem_din and the write flag come from the latches. The counter increments each cycle.
  - mem_we is high only on the first ACCESS cycle, and only for a write (single write strobe).
  - When the counter equals MEM_LAT-1, capture mem_dout into the owner's rdata register and go to RESP.
  - Counter width is $clog2(MEM_LAT+1).
- RESP:
  - Pulse the owner's ack for exactly one cycle, then return to IDLE.
  - The non-owner's ack stays 0. The non-owner's rdata is unchanged.
- Requests are sampled only in IDLE. A req held high after its ack counts as a new transaction at the next IDLE.
- Requester signals are latched at grant, so changes to addr/wdata after grant have no effect.
- If a requester drops req mid-transaction, the transaction still completes and the ack still pulses.
- Default priority: dm wins a tie, so the older instruction's memory op completes first.
- rdata on writes: dm_rdata holds its previous value.
- mem_addr and mem_din hold their last latched value outside ACCESS. mem_we is 0 outside the first ACCESS cycle.
- Reset values: state IDLE; if_ack 0, dm_ack 0; if_rdata 0, dm_rdata 0; mem_addr 0, mem_din 0, mem_we 0; busy 0; counter 0; last-grant pointer = IF.
- Reset mid-operation (any state): the transaction is abandoned and no ack is issued. mem_we is 0 from the reset edge onward.

## Timing
- Request sampled in IDLE at cycle t: ACCESS covers t+1 … t+MEM_LAT, RESP is t+MEM_LAT+1.
- Ack latency is therefore MEM_LAT+1 cycles after the sampling edge.
- Minimum transaction length is MEM_LAT+2 cycles, IDLE included. Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- All outputs are registered except busy, which is decoded from the state register.
- No combinational path from any input to any output.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the requester not granted last.
  - The last-grant pointer updates on each grant.
  - A lone requester is always granted.
- ARB_RR_EN undefined: fixed priority, dm over if. The pointer register is not implemented.

## Structure
- Package mem_arb_pkg holds:
  - the state enum: IDLE, ACCESS, RESP
  - owner encoding: OWN_IF=0, OWN_DM=1
  - default width constants
- One sub-module, arb_pick2: combinational two-requester picker.
  - Inputs: req pair and last-grant pointer. Output: owner.
  - Round-robin logic lives under ARB_RR_EN.
- FSM, latches, counter and response registers live in mem_port_arbiter.

## Test plan
- Reset: assert reset 2 cycles with both reqs high → all outputs 0, busy 0, no ack for 3 cycles after release minus the first grant path.
- Fetch read, MEM_LAT=1, if_addr=0x40, memory word 0x2002000A → if_ack at t+2, if_rdata=0x2002000A, mem_we never high, dm_ack 0.
- Data write, dm_addr=0x100, dm_wdata=0xDEADBEEF, then a read of 0x100:
  - mem_we high for exactly 1 cycle with mem_addr=0x100 and mem_din=0xDEADBEEF; dm_ack at t+2.
  - The read returns dm_rdata=0xDEADBEEF.
- Both reqs held high for 4 transactions:
  - Without ARB_RR_EN → grant order DM,DM,DM,DM.
  - With ARB_RR_EN → DM,IF,DM,IF.
- MEM_LAT=3, fetch read → busy 4 cycles; if_ack at t+4; if_rdata equals mem_dout from the third ACCESS cycle.
- Reset asserted during the first ACCESS cycle of a write → mem_we 0 after the edge, no dm_ack, state IDLE, busy 0 next cycle.
